// File: rtl/io_wait_state_generator_pkg.sv
// Shared types and constants for the I/O wait-state generator and its neighbours.
package io_wait_state_generator_pkg;

  localparam int unsigned CounterWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } wait_state_e;

endpackage

// File: rtl/cpu_clock_edge_detect.sv
// Rising-edge detector for the CPU clock level, sampled in the system clock domain.
module cpu_clock_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic cpu_clock,
  output logic cpu_clock_rise
);

  logic prev_cpu_clock_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_cpu_clock_q <= 1'b0;
    end else begin
      prev_cpu_clock_q <= cpu_clock;
    end
  end

  assign cpu_clock_rise = cpu_clock & ~prev_cpu_clock_q;

endmodule

// File: rtl/io_wait_state_generator.sv
// Inserts a programmable number of CPU-clock wait states on CPU I/O and memory bus cycles
// by holding the registered channel-ready line low.
module io_wait_state_generator
  import io_wait_state_generator_pkg::*;
#(
  parameter int unsigned IO_WAIT_CYCLES  = 1,
  parameter int unsigned MEM_WAIT_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic cpu_clock,
  input  logic address_enable_n,
  input  logic io_read_n,
  input  logic io_write_n,
  input  logic memory_read_n,
  input  logic memory_write_n,
  input  logic ext_io_channel_ready,
  output logic io_channel_ready,
  output logic wait_active
);

  localparam logic [CounterWidth-1:0] IoCount  = CounterWidth'(IO_WAIT_CYCLES);
  localparam logic [CounterWidth-1:0] MemCount = CounterWidth'(MEM_WAIT_CYCLES);

  logic                    cpu_clock_rise;
  logic                    io_cmd;
  logic                    mem_cmd;
  logic                    cmd;
  logic                    start;
  logic [CounterWidth-1:0] start_count;
  logic                    prev_cmd_q;
  logic [CounterWidth-1:0] count_q, count_d;
  wait_state_e             state_q, state_d;

  cpu_clock_edge_detect u_cpu_clock_edge_detect (
    .clock          (clock),
    .reset          (reset),
    .cpu_clock      (cpu_clock),
    .cpu_clock_rise (cpu_clock_rise)
  );

  // DMA cycles drop address_enable_n, which masks every command term.
  assign io_cmd      = address_enable_n & (~io_read_n | ~io_write_n);
  assign mem_cmd     = address_enable_n & (~memory_read_n | ~memory_write_n);
  assign cmd         = io_cmd | mem_cmd;
  assign start       = cmd & ~prev_cmd_q;
  assign start_count = io_cmd ? IoCount : MemCount;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (start_count != '0) begin
            count_d = start_count;
            state_d = StWait;
          end else begin
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (!cmd) begin
          state_d = StIdle;
        end else if (cpu_clock_rise) begin
          count_d = count_q - CounterWidth'(1);
          if (count_q == CounterWidth'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!cmd) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // prev_cmd resets high so a command already active across reset needs a fresh 0->1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      count_q          <= '0;
      prev_cmd_q       <= 1'b1;
      io_channel_ready <= 1'b1;
      wait_active      <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      prev_cmd_q       <= cmd;
      io_channel_ready <= (state_d != StWait) & ext_io_channel_ready;
      wait_active      <= (state_d == StWait);
    end
  end

endmodule
